// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer
//
// Purpose:
//   Sits between a sample source and a fir_filter socket. Incoming signed
//   samples are buffered in a small FIFO and handed to the filter one at a
//   time as single-cycle fir_ready strobes. Consecutive strobes are at least
//   SPACING cycles apart. After each strobe the filter result is captured
//   LATENCY cycles later and offered downstream on a valid/ready stream.
//   Only one sample is in flight at any time.
//
// Optional feature (macro FIR_SEQ_CMP_EN):
//   When FIR_SEQ_CMP_EN is defined, the filter output is compared against
//   the output of a second filter (fir_out_sep) at every capture. A sticky
//   mismatch flag and a saturating 8-bit mismatch counter are provided.
//   When the macro is not defined those ports and the logic are absent.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   s_data       in   upstream signed sample
//   s_valid      in   upstream sample valid
//   s_ready      out  FIFO can accept a sample (low while rst is high)
//   fir_in       out  sample driven to the filter, held between strobes
//   fir_ready    out  one-cycle strobe to the filter
//   fir_out      in   filter result
//   fir_out_sep  in   second filter result        (FIR_SEQ_CMP_EN only)
//   mismatch     out  sticky compare failure flag (FIR_SEQ_CMP_EN only)
//   mismatch_cnt out  saturating failure counter  (FIR_SEQ_CMP_EN only)
//   m_data       out  captured filter result
//   m_valid      out  m_data valid
//   m_ready      in   downstream accepts m_data
//   busy         out  FSM not idle or FIFO not empty

module fir_sample_sequencer #(
  parameter int DW         = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int SPACING    = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [DW-1:0] fir_in,
  output logic                 fir_ready,
  input  logic signed [DW-1:0] fir_out,
`ifdef FIR_SEQ_CMP_EN
  input  logic signed [DW-1:0] fir_out_sep,
  output logic                 mismatch,
  output logic [7:0]           mismatch_cnt,
`endif
  output logic signed [DW-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_e;

  state_e               state_q;
  logic signed [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, wrPtr_d;
  logic [AW-1:0]        rdPtr_q, rdPtr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        spacing_q;
  logic [LW-1:0]        waitCnt_q;
  logic signed [DW-1:0] fir_in_q;
  logic                 fir_ready_q;
  logic signed [DW-1:0] m_data_q;
  logic                 m_valid_q;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 push;
  logic                 issueNow;

  // FIFO status and handshakes. A full FIFO refuses a push even when the
  // same cycle pops, which keeps s_ready independent of the FSM.
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(FIFO_DEPTH));
  assign s_ready   = !fifoFull && !rst;
  assign push      = s_valid && s_ready;

  // The strobe is launched from IDLE: the head is registered into fir_in and
  // popped on the same edge, so fir_ready is high during the ISSUE cycle.
  assign issueNow  = (state_q == IDLE) && !fifoEmpty && (spacing_q == '0);

  assign fir_in    = fir_in_q;
  assign fir_ready = fir_ready_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = !rst && ((state_q != IDLE) || !fifoEmpty);

  // Next-state pointers and occupancy; pointer wrap relies on FIFO_DEPTH
  // being a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (issueNow) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(issueNow);
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= s_data;
    end
  end

  // Spacing counter runs regardless of FSM state. Loading SPACING-1 on the
  // launch edge and issuing only at zero puts strobes exactly SPACING apart
  // when the FIFO is never starved.
  always_ff @(posedge clk) begin
    if (rst) begin
      spacing_q <= '0;
    end else if (issueNow) begin
      spacing_q <= SW'(SPACING - 1);
    end else if (spacing_q != '0) begin
      spacing_q <= spacing_q - SW'(1);
    end
  end

  // Main sequencer. The wait counter is loaded with LATENCY at launch, held
  // through ISSUE and counted down in WAIT; capturing when it reads 1 lands
  // the capture edge exactly LATENCY cycles after the strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fir_ready_q  <= 1'b0;
      fir_in_q     <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      waitCnt_q    <= '0;
`ifdef FIR_SEQ_CMP_EN
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (issueNow) begin
            state_q     <= ISSUE;
            fir_ready_q <= 1'b1;
            fir_in_q    <= mem_q[rdPtr_q];
            waitCnt_q   <= LW'(LATENCY);
          end
        end
        ISSUE: begin
          fir_ready_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (waitCnt_q == LW'(1)) begin
            m_data_q  <= fir_out;
            m_valid_q <= 1'b1;
            state_q   <= HOLD;
`ifdef FIR_SEQ_CMP_EN
            if (fir_out != fir_out_sep) begin
              mismatch <= 1'b1;
              if (mismatch_cnt != 8'hFF) begin
                mismatch_cnt <= mismatch_cnt + 8'd1;
              end
            end
`endif
          end else begin
            waitCnt_q <= waitCnt_q - LW'(1);
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Testbench for fir_sample_sequencer.
// The filter is modelled as "output = 2 x input", valid only in the single
// cycle LATENCY after the strobe and random junk at every other time.
// Expected outputs come from a queue of doubled accepted samples.

module tb_fir_sample_sequencer;

  localparam int DW  = 18;
  localparam int FD  = 4;
  localparam int SP  = 8;
  localparam int LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] fir_in;
  logic                 fir_ready;
  logic signed [DW-1:0] fir_out;
  logic signed [DW-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 busy;
`ifdef FIR_SEQ_CMP_EN
  logic signed [DW-1:0] fir_out_sep;
  logic                 mismatch;
  logic [7:0]           mismatch_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic signed [DW-1:0] expQ[$];
  logic signed [DW-1:0] outQ[$];
  int                   strobeCyc[$];

  fir_sample_sequencer #(
    .DW(DW), .FIFO_DEPTH(FD), .SPACING(SP), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .fir_in(fir_in),
    .fir_ready(fir_ready),
    .fir_out(fir_out),
`ifdef FIR_SEQ_CMP_EN
    .fir_out_sep(fir_out_sep),
    .mismatch(mismatch),
    .mismatch_cnt(mismatch_cnt),
`endif
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Filter model: a doubled copy of fir_in travels down a LAT-deep delay
  // line and is presented only in the one cycle it is due.
  logic signed [DW-1:0] pipeD [LAT];
  logic                 pipeV [LAT];
  logic                 pipeS [LAT];
  logic signed [DW-1:0] junk;
  int                   strobeIdx;

  always @(posedge clk) begin
    pipeV[0] <= rst ? 1'b0 : fir_ready;
    pipeD[0] <= fir_in + fir_in;
    pipeS[0] <= (strobeIdx == 2);
    for (int i = 1; i < LAT; i++) begin
      pipeV[i] <= pipeV[i-1];
      pipeD[i] <= pipeD[i-1];
      pipeS[i] <= pipeS[i-1];
    end
    junk <= DW'($urandom);
    if (rst) strobeIdx <= 0;
    else if (fir_ready) strobeIdx <= strobeIdx + 1;
  end

  assign fir_out = pipeV[LAT-1] ? pipeD[LAT-1] : junk;
`ifdef FIR_SEQ_CMP_EN
  assign fir_out_sep = (pipeV[LAT-1] && pipeS[LAT-1]) ? fir_out + 1 : fir_out;
`endif

  // Observation at the falling edge: accepted samples feed the reference
  // queue, strobes and delivered outputs are logged for the tests.
  always @(negedge clk) begin
    logic signed [DW-1:0] dbl;
    if (rst) begin
      expQ.delete();
    end else begin
      if (s_valid && s_ready) begin
        dbl = s_data + s_data;
        expQ.push_back(dbl);
      end
      if (fir_ready) strobeCyc.push_back(cyc);
      if (m_valid && m_ready) outQ.push_back(m_data);
    end
  end

  // Reset the DUT for two cycles and clear all logs.
  task automatic applyStimulus_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    expQ.delete(); outQ.delete(); strobeCyc.delete();
  endtask

  // Offer one sample and wait (bounded) until it is accepted.
  task automatic pushOne(input logic signed [DW-1:0] v);
    int n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = v;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("[TB] FAIL push_timeout: s_ready=%0b required 1", s_ready);
    end
  endtask

  task automatic releaseInput();
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Wait (bounded) until the given number of outputs has been delivered.
  task automatic waitOutputs(input int n);
    int k = 0;
    while (outQ.size() < n && k < 500) begin @(negedge clk); k++; end
    checks++;
    if (outQ.size() < n) begin
      errors++;
      $display("[TB] FAIL drain_timeout: outputs=%0d required %0d", outQ.size(), n);
    end
  endtask

  function automatic logic signed [DW-1:0] randSample();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return r >>> 2;
  endfunction

  // Outputs are zero during reset and the stream opens once reset drops.
  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b1; s_data = randSample(); m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks += 6;
      if (fir_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_fir_ready: got %0b want 0", fir_ready); end
      if (fir_in !== '0)      begin errors++; $display("[TB] FAIL rst_fir_in: got %0d want 0", fir_in); end
      if (m_data !== '0)      begin errors++; $display("[TB] FAIL rst_m_data: got %0d want 0", m_data); end
      if (m_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rst_m_valid: got %0b want 0", m_valid); end
      if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy: got %0b want 0", busy); end
      if (s_ready !== 1'b0)   begin errors++; $display("[TB] FAIL rst_s_ready: got %0b want 0", s_ready); end
      @(posedge clk); #1;
    end
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_s_ready: got %0b want 1", s_ready); end
    if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL post_rst_busy: got %0b want 0", busy); end
    expQ.delete(); outQ.delete(); strobeCyc.delete();
  endtask

  // One sample of 1000: strobe in cycle 2, output 2000 in cycle 5.
  task automatic test_single();
    applyStimulus_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      s_valid = (k == 0); s_data = 18'sd1000;
      @(negedge clk);
      checks += 2;
      if (fir_ready !== (k == 2)) begin errors++; $display("[TB] FAIL single_fir_ready c%0d: got %0b want %0b", k, fir_ready, (k == 2)); end
      if (m_valid !== (k == 5))   begin errors++; $display("[TB] FAIL single_m_valid c%0d: got %0b want %0b", k, m_valid, (k == 5)); end
      if (k >= 2) begin
        checks++;
        if (fir_in !== 18'sd1000) begin errors++; $display("[TB] FAIL single_fir_in c%0d: got %0d want 1000", k, fir_in); end
      end
      if (k == 5) begin
        checks++;
        if (m_data !== 18'sd2000) begin errors++; $display("[TB] FAIL single_m_data: got %0d want 2000", m_data); end
      end
    end
  endtask

  // Six back-to-back samples: strobes exactly SP apart, outputs in order.
  task automatic test_spacing();
    applyStimulus_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) pushOne(randSample());
    releaseInput();
    waitOutputs(6);
    checks++;
    if (strobeCyc.size() !== 6) begin errors++; $display("[TB] FAIL spacing_count: got %0d want 6", strobeCyc.size()); end
    for (int i = 1; i < strobeCyc.size(); i++) begin
      checks++;
      if (strobeCyc[i] - strobeCyc[i-1] !== SP) begin
        errors++; $display("[TB] FAIL spacing_gap%0d: got %0d want %0d", i, strobeCyc[i] - strobeCyc[i-1], SP);
      end
    end
    for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (outQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL spacing_data%0d: got %0d want %0d", i, outQ[i], expQ[i]); end
    end
  endtask

  // Stalled output: FIFO plus in-flight hold 5 samples, m_data stays put and
  // no new strobe appears; afterwards all 7 samples emerge in order.
  task automatic test_full_backpressure();
    logic signed [DW-1:0] samples [7];
    logic signed [DW-1:0] held;
    int idx = 0;
    applyStimulus_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) samples[i] = randSample();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = samples[idx];
      @(negedge clk);
      if (s_ready) idx++;
    end
    checks += 4;
    if (idx !== 5)        begin errors++; $display("[TB] FAIL full_accepted: got %0d want 5", idx); end
    if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_s_ready: got %0b want 0", s_ready); end
    if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_m_valid: got %0b want 1", m_valid); end
    if (busy !== 1'b1)    begin errors++; $display("[TB] FAIL full_busy: got %0b want 1", busy); end
    held = m_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks += 4;
      if (m_data !== held)    begin errors++; $display("[TB] FAIL hold_m_data c%0d: got %0d want %0d", c, m_data, held); end
      if (m_valid !== 1'b1)   begin errors++; $display("[TB] FAIL hold_m_valid c%0d: got %0b want 1", c, m_valid); end
      if (fir_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_strobe c%0d: got %0b want 0", c, fir_ready); end
      if (busy !== 1'b1)      begin errors++; $display("[TB] FAIL hold_busy c%0d: got %0b want 1", c, busy); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = idx; i < 7; i++) pushOne(samples[i]);
    releaseInput();
    waitOutputs(7);
    for (int i = 0; i < 7 && i < outQ.size(); i++) begin
      logic signed [DW-1:0] want;
      want = samples[i] + samples[i];
      checks++;
      if (outQ[i] !== want) begin errors++; $display("[TB] FAIL full_data%0d: got %0d want %0d", i, outQ[i], want); end
    end
  endtask

  // Reset one cycle after the strobe drops the in-flight sample.
  task automatic test_reset_in_wait();
    int n = 0;
    applyStimulus_reset();
    m_ready = 1'b1;
    pushOne(randSample());
    releaseInput();
    @(negedge clk);
    while (!fir_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (fir_ready !== 1'b1) begin errors++; $display("[TB] FAIL rwait_strobe: got %0b want 1", fir_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rwait_s_ready_in_rst: got %0b want 0", s_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rwait_s_ready: got %0b want 1", s_ready); end
    if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL rwait_busy: got %0b want 0", busy); end
    if (fir_in !== '0)    begin errors++; $display("[TB] FAIL rwait_fir_in: got %0d want 0", fir_in); end
    if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rwait_m_valid: got %0b want 0", m_valid); end
    repeat (10) @(negedge clk);
    checks += 2;
    if (outQ.size() !== 0)  begin errors++; $display("[TB] FAIL rwait_outputs: got %0d want 0", outQ.size()); end
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rwait_busy_late: got %0b want 0", busy); end
  endtask

  // Random traffic with random downstream stalls.
  task automatic test_random();
    logic                 prevStall = 1'b0;
    logic signed [DW-1:0] prevData = '0;
    applyStimulus_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = randSample();
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prevStall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prevData) begin
          errors++; $display("[TB] FAIL rand_stable c%0d: got v=%0b d=%0d want v=1 d=%0d", c, m_valid, m_data, prevData);
        end
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    waitOutputs(expQ.size());
    for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (outQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rand_data%0d: got %0d want %0d", i, outQ[i], expQ[i]); end
    end
    for (int i = 1; i < strobeCyc.size(); i++) begin
      checks++;
      if (strobeCyc[i] - strobeCyc[i-1] < SP) begin
        errors++; $display("[TB] FAIL rand_gap%0d: got %0d want >=%0d", i, strobeCyc[i] - strobeCyc[i-1], SP);
      end
    end
  endtask

`ifdef FIR_SEQ_CMP_EN
  // Second filter disagrees on the third sample only.
  task automatic test_mismatch();
    applyStimulus_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) pushOne(randSample());
    releaseInput();
    waitOutputs(2);
    checks += 2;
    if (mismatch !== 1'b0)      begin errors++; $display("[TB] FAIL cmp_early: got %0b want 0", mismatch); end
    if (mismatch_cnt !== 8'd0)  begin errors++; $display("[TB] FAIL cmp_early_cnt: got %0d want 0", mismatch_cnt); end
    waitOutputs(5);
    checks += 2;
    if (mismatch !== 1'b1)      begin errors++; $display("[TB] FAIL cmp_flag: got %0b want 1", mismatch); end
    if (mismatch_cnt !== 8'd1)  begin errors++; $display("[TB] FAIL cmp_cnt: got %0d want 1", mismatch_cnt); end
  endtask
`endif

  // Global bound on simulated time.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_spacing();
    test_full_backpressure();
    test_reset_in_wait();
    test_random();
`ifdef FIR_SEQ_CMP_EN
    test_mismatch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Sequencer in front of `fir_filter`. Buffers signed samples from an upstream valid/ready stream and issues them to the filter as single-cycle `ready` strobes no closer than a programmed spacing. It then captures the filter output after a fixed latency and presents it downstream on a valid/ready stream. It sits between the sample source and the filter socket and replaces free-running strobe generation.

## Interface
- `DW`, 18: sample width, signed, same for input and output.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `SPACING`, 8: minimum cycles between consecutive `fir_ready` strobes; ≥1.
- `LATENCY`, 2: cycles from a strobe to a valid `fir_out`; ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_data` in DW: upstream sample.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: FIFO can accept a sample.
- `fir_in` out DW: sample driven to the filter's `input_sig`.
- `fir_ready` out 1: one-cycle strobe to the filter's `ready`.
- `fir_out` in DW: filter `filtred_sig`.
- `m_data` out DW: captured filtered sample.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: downstream accepts.
- `busy` out 1: high in every state except IDLE, or while the FIFO is non-empty.
- `fir_out_sep`, `mismatch`, `mismatch_cnt[7:0]`: present only with the macro (see Configuration).

## Operation
- FIFO push: on `s_valid && s_ready`. `s_ready = !full && !rst`. A push is refused when the FIFO is full, even if a pop occurs in the same cycle. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - **IDLE → ISSUE:** when the FIFO is non-empty and the spacing counter has expired.
  - **ISSUE (1 cycle):** `fir_ready`=1 and `fir_in`=FIFO head, both registered. Pop the FIFO, load the wait counter with `LATENCY`, load the spacing counter with `SPACING`-1.
  - **WAIT:** count down. On the cycle that is `LATENCY` after ISSUE, register `fir_out` into `m_data`, set `m_valid`, and go to HOLD.
  - **HOLD:** on `m_valid && m_ready`, clear `m_valid` and go to IDLE.
- `fir_in` holds its last issued value between strobes.
- Data passes through unchanged: signed, no rounding or saturation.
- The spacing counter runs independently of the FSM and saturates at 0 (expired).
- Only one sample is in flight. Effective period = max(`SPACING`, `LATENCY`+3 + downstream stall).
- Reset (any cycle, including mid-WAIT/HOLD) takes effect at the next edge:
  - FIFO empties and the in-flight sample is dropped.
  - FSM goes to IDLE and the spacing counter is expired.
  - `fir_ready`=0, `fir_in`=0, `m_data`=0, `m_valid`=0, `busy`=0, `s_ready`=0 while `rst` is high.

## Timing
- Push at cycle 0 → head visible cycle 1 → `fir_ready` high cycle 2 (if spacing is expired) → `fir_out` sampled at the end of cycle 2+`LATENCY` → `m_valid` high from cycle 3+`LATENCY` (cycle 5 at the defaults).
- Strobes at cycles t and t' always satisfy t'−t ≥ `SPACING`.
- `fir_ready` is never high in two consecutive cycles.
- `m_data` is stable while `m_valid && !m_ready`.

## Configuration
- **`FIR_SEQ_CMP_EN` defined:**
  - Adds input `fir_out_sep[DW]` (from `fir_filter_sep`) and outputs `mismatch` and `mismatch_cnt`.
  - At capture, if `fir_out != fir_out_sep`, `mismatch` is set sticky and `mismatch_cnt` increments, saturating at 255.
  - Both are cleared only by `rst` and are 0 at reset.
- **Not defined:** these ports and logic are absent. Behaviour is otherwise identical.

## Test plan
- **Single sample:** `rst` low, push 18'sd1000 at cycle 0, `fir_out` model = input×2 with `LATENCY`=2 → `fir_ready` high only in cycle 2 with `fir_in`=1000; `m_valid` in cycle 5 with `m_data`=2000.
- **Spacing:** push 6 samples back-to-back with `m_ready`=1, `SPACING`=8 → strobe cycles differ by exactly 8, outputs in order, no loss.
- **Full FIFO:** hold `m_ready`=0 and push 7 samples → `s_ready` falls after 4 FIFO entries plus 1 in flight. The 6th and later pushes stall until `m_ready`=1. All 5 accepted samples emerge in order.
- **Backpressure:** `m_ready`=0 for 10 cycles in HOLD → `m_data` is constant, no new strobe, `busy`=1.
- **Reset in WAIT:** assert `rst` for 1 cycle in the cycle after a strobe → no `m_valid` from that sample, FIFO empty, `s_ready`=1 the cycle after `rst` falls.
- **With `FIR_SEQ_CMP_EN`:** `fir_out_sep` = `fir_out`+1 on the 3rd sample only → `mismatch` rises after the 3rd capture and stays high, `mismatch_cnt`=1.
